// File: rtl/serial_sub5_if.sv
// Operand/result handshake bundle for serial_sub5.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub5_if #(
    parameter int unsigned WIDTH = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bo;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, bo, ovf
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, bo, ovf
    );
`else
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, bo
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, bo
    );
`endif
endinterface

// File: rtl/serial_sub5.sv
// Bit-serial ripple subtractor: diff = a - b, one bit per clock, LSB first.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub5 #(
    parameter int unsigned WIDTH = 5
) (
    input  logic         clk,
    input  logic         rst,
    serial_sub5_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RES_W = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bo_q, bo_d;
`ifdef SERIAL_SUB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic ai, bi, d_bit, br_nxt;

    // One full-subtractor slice operating on the current LSBs.
    always_comb begin
        ai     = sa_q[0];
        bi     = sb_q[0];
        d_bit  = ai ^ bi ^ br_q;
        br_nxt = (~ai & bi) | (~(ai ^ bi) & br_q);
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bo_d    = bo_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                res_d = RES_W'({d_bit, res_q} >> 1);
                br_d  = br_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                // res_q already holds the lower WIDTH-1 result bits here.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    diff_d  = {d_bit, res_q};
                    bo_d    = br_nxt;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (ai ^ bi) & (ai ^ d_bit);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bo_q    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bo_q    <= bo_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Handshake flags decode registered state only.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.bo        = bo_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule
